// File: rtl/dbuf_tx_framer.sv
// Data-buffer transmitter: word RAM plus a framer that sends K_START, payload, K_STOP and a 16-bit checksum.
// Optional `DBUF_TX_SEGMENT_EN adds seg_id, sent right after K_START and covered by the checksum.
module dbuf_tx_framer #(
  parameter int         DEPTH   = 512,
  parameter logic [7:0] K_START = 8'h5C,
  parameter logic [7:0] K_STOP  = 8'h3C
) (
  input  logic                     tx_clk,
  input  logic                     aresetn,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
`ifdef DBUF_TX_SEGMENT_EN
  input  logic [7:0]               seg_id,
`endif
  input  logic                     tx_slot,
  output logic [7:0]               tx_data,
  output logic                     tx_charisk,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SOF,
`ifdef DBUF_TX_SEGMENT_EN
    S_SEG,
`endif
    S_DATA,
    S_EOF,
    S_CSH,
    S_CSL
  } state_t;

  state_t              r_state, w_next_state;
  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_rd_data;
  logic [LEN_W-1:0]    r_len, r_word_idx;
  logic [1:0]          r_byte_idx;
  logic [15:0]         r_csum;
  logic                r_done, r_err;
`ifdef DBUF_TX_SEGMENT_EN
  logic [7:0]          r_seg_id;
`endif

  logic                w_we, w_re, w_len_ok, w_start_ok, w_start_bad;
  logic                w_last_byte, w_last_word;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [LEN_W-1:0]    w_word_nxt;
  logic [7:0]          w_byte;

  assign busy        = (r_state != S_IDLE);
  assign wr_ready    = !busy;
  assign done        = r_done;
  assign err         = r_err;
  assign w_we        = wr_valid && wr_ready;
  assign w_len_ok    = (len != '0) && (len <= LEN_W'(DEPTH));
  assign w_start_ok  = (r_state == S_IDLE) && start && w_len_ok;
  assign w_start_bad = (r_state == S_IDLE) && start && !w_len_ok;
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_idx == r_len - 1'b1);
  assign w_word_nxt  = r_word_idx + 1'b1;
  assign w_byte      = r_rd_data[{r_byte_idx, 3'b000} +: 8];

  // NOTE: the RAM has no reset; its contents are defined only by software writes.
  always_ff @(posedge tx_clk) begin
    if (w_we) r_mem[wr_addr] <= wr_data;
    // A start in the same cycle as a write to the word being read must see the new data.
    if (w_re) r_rd_data <= (w_we && (wr_addr == w_rd_addr)) ? wr_data : r_mem[w_rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge tx_clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_re         = 1'b0;
    w_rd_addr    = '0;
    tx_data      = 8'h00;
    tx_charisk   = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_ok) begin
        w_next_state = S_PRE;
        w_re         = 1'b1;
      end
      S_PRE: w_next_state = S_SOF;
      S_SOF: if (tx_slot) begin
        tx_data    = K_START;
        tx_charisk = 1'b1;
`ifdef DBUF_TX_SEGMENT_EN
        w_next_state = S_SEG;
`else
        w_next_state = S_DATA;
`endif
      end
`ifdef DBUF_TX_SEGMENT_EN
      S_SEG: if (tx_slot) begin
        tx_data      = r_seg_id;
        w_next_state = S_DATA;
      end
`endif
      S_DATA: if (tx_slot) begin
        tx_data = w_byte;
        if (w_last_byte) begin
          if (w_last_word) w_next_state = S_EOF;
          else begin
            w_re      = 1'b1;
            w_rd_addr = w_word_nxt[ADDR_W-1:0];
          end
        end
      end
      S_EOF: if (tx_slot) begin
        tx_data      = K_STOP;
        tx_charisk   = 1'b1;
        w_next_state = S_CSH;
      end
      S_CSH: if (tx_slot) begin
        tx_data      = r_csum[15:8];
        w_next_state = S_CSL;
      end
      S_CSL: if (tx_slot) begin
        tx_data      = r_csum[7:0];
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_csum     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef DBUF_TX_SEGMENT_EN
      r_seg_id   <= '0;
`endif
    end else begin
      r_done <= (r_state == S_CSL) && tx_slot;
      r_err  <= w_start_bad;
      if (w_start_ok) begin
        r_len      <= len;
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_csum     <= 16'hFFFF;
`ifdef DBUF_TX_SEGMENT_EN
        r_seg_id   <= seg_id;
`endif
      end else if (tx_slot) begin
`ifdef DBUF_TX_SEGMENT_EN
        if (r_state == S_SEG) r_csum <= r_csum - {8'h00, r_seg_id};
`endif
        if (r_state == S_DATA) begin
          r_csum     <= r_csum - {8'h00, w_byte};
          r_byte_idx <= r_byte_idx + 1'b1;
          if (w_last_byte) r_word_idx <= w_word_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_dbuf_tx_framer.sv
// Bench for dbuf_tx_framer: frame-level byte-queue model checked every cycle, plus literal frame checks.
module tb_dbuf_tx_framer;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int LW    = 10;

  logic          tx_clk = 1'b0, aresetn = 1'b0;
  logic          wr_valid = 1'b0, start = 1'b0, tx_slot = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [LW-1:0] len = '0;
  logic [7:0]    tx_data;
  logic          tx_charisk, busy, done, err;
`ifdef DBUF_TX_SEGMENT_EN
  logic [7:0]    seg_id = '0;
`endif

  int total = 0, bad = 0;
  int slot_mode = 0;

  logic [31:0] m_mem [DEPTH];
  logic [8:0]  m_q[$];
  bit          m_active = 1'b0, m_done_nx = 1'b0, m_err_nx = 1'b0;
  int          m_pre = 0;
  logic [8:0]  obs[$];
  int          n_done = 0, n_err = 0;

  always #5 tx_clk = ~tx_clk;

  dbuf_tx_framer #(.DEPTH(DEPTH)) dut (
    .tx_clk(tx_clk), .aresetn(aresetn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len),
`ifdef DBUF_TX_SEGMENT_EN
    .seg_id(seg_id),
`endif
    .tx_slot(tx_slot), .tx_data(tx_data), .tx_charisk(tx_charisk),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected frame as {is_k, byte}: start char, optional segment id, payload LSB first, stop char, checksum.
  function automatic void build_frame(input int n);
    logic [15:0] cs = 16'hFFFF;
    logic [7:0]  b;
    m_q.delete();
    m_q.push_back({1'b1, 8'h5C});
`ifdef DBUF_TX_SEGMENT_EN
    m_q.push_back({1'b0, seg_id});
    cs = cs - {8'h00, seg_id};
`endif
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) begin
        b  = m_mem[w][8*k +: 8];
        m_q.push_back({1'b0, b});
        cs = cs - {8'h00, b};
      end
    m_q.push_back({1'b1, 8'h3C});
    m_q.push_back({1'b0, cs[15:8]});
    m_q.push_back({1'b0, cs[7:0]});
  endfunction

  initial forever begin
    @(negedge tx_clk);
    case (slot_mode)
      0:       tx_slot = 1'b1;
      1:       tx_slot = ~tx_slot;
      default: tx_slot = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: check outputs for this cycle, then advance the model across the coming edge.
  initial begin
    logic [8:0] exp_b;
    bit         emit, old_act;
    forever begin
      @(negedge tx_clk); #3;
      if (!aresetn) begin
        check("reset_outputs", {tx_data, tx_charisk, busy, done, err, wr_ready}, {8'h00, 5'b00001});
        m_active = 1'b0; m_pre = 0; m_q.delete(); m_done_nx = 1'b0; m_err_nx = 1'b0;
      end else begin
        emit  = m_active && (m_pre == 0) && tx_slot;
        exp_b = emit ? m_q[0] : 9'h000;
        check("tx_byte", {23'h0, tx_charisk, tx_data}, {23'h0, exp_b});
        check("busy", busy, m_active);
        check("wr_ready", wr_ready, !m_active);
        check("done", done, m_done_nx);
        check("err", err, m_err_nx);
        if (done) n_done++;
        if (err) n_err++;
        if (emit) obs.push_back({tx_charisk, tx_data});
        old_act   = m_active;
        m_done_nx = 1'b0;
        m_err_nx  = 1'b0;
        if (old_act) begin
          if (m_pre > 0) m_pre--;
          else if (tx_slot) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin m_active = 1'b0; m_done_nx = 1'b1; end
          end
        end
        if (wr_valid && !old_act) m_mem[wr_addr] = wr_data;
        if (start && !old_act) begin
          if (len == 0 || len > DEPTH) m_err_nx = 1'b1;
          else begin build_frame(int'(len)); m_active = 1'b1; m_pre = 1; end
        end
      end
    end
  end

  task automatic write_word(input int a, input logic [31:0] d);
    @(negedge tx_clk); wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge tx_clk); wr_valid = 1'b0;
  endtask

  task automatic start_frame(input int n);
    @(negedge tx_clk); start = 1'b1; len = LW'(n);
    @(negedge tx_clk); start = 1'b0;
  endtask

  task automatic write_and_start(input int a, input logic [31:0] d, input int n);
    @(negedge tx_clk); wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d; start = 1'b1; len = LW'(n);
    @(negedge tx_clk); wr_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((m_active || busy) && c < budget) begin @(negedge tx_clk); #4; c++; end
    check("idle_timeout", 32'(c < budget), 1);
    repeat (2) @(negedge tx_clk);
  endtask

  task automatic check_obs(input string nm, input logic [8:0] e[$]);
    check({nm, "_len"}, obs.size(), e.size());
    for (int i = 0; i < e.size() && i < obs.size(); i++)
      check(nm, {23'h0, obs[i]}, {23'h0, e[i]});
  endtask

  initial begin
    logic [8:0] e[$];
    int d0, e0, n;
    repeat (3) @(negedge tx_clk);
    aresetn = 1'b1;
    @(negedge tx_clk); #4;
    check("post_reset_ready", wr_ready, 1);
    check("post_reset_busy", busy, 0);

    // Single word, slot every other cycle.
    slot_mode = 1;
    write_word(0, 32'h04030201);
    obs.delete(); d0 = n_done;
    start_frame(1); wait_idle(200);
    e = '{9'h15C, 9'h001, 9'h002, 9'h003, 9'h004, 9'h13C, 9'h0FF, 9'h0F5};
`ifndef DBUF_TX_SEGMENT_EN
    check_obs("t1_frame", e);
`endif
    check("t1_done_count", n_done - d0, 1);
    check("t1_busy_after", busy, 0);

    // Two words, continuous slots.
    slot_mode = 0;
    write_word(0, 32'h00000000);
    write_word(1, 32'hFFFFFFFF);
    obs.delete();
    start_frame(2); wait_idle(200);
    e = '{9'h15C, 9'h000, 9'h000, 9'h000, 9'h000, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF,
          9'h13C, 9'h0FC, 9'h003};
`ifndef DBUF_TX_SEGMENT_EN
    check_obs("t2_frame", e);
`endif

    // Full buffer: checksum wraps; then an oversize length is rejected.
    for (int i = 0; i < DEPTH; i++) write_word(i, 32'hFFFFFFFF);
    obs.delete();
    start_frame(DEPTH); wait_idle(5000);
`ifndef DBUF_TX_SEGMENT_EN
    check("t3_len", obs.size(), 4*DEPTH + 4);
    check("t3_csh", {23'h0, obs[obs.size()-2]}, 32'h007);
    check("t3_csl", {23'h0, obs[obs.size()-1]}, 32'h0FF);
`endif
    e0 = n_err;
    start_frame(DEPTH + 1);
    repeat (2) @(negedge tx_clk); #4;
    check("t3_err_count", n_err - e0, 1);
    check("t3_busy_stays_low", busy, 0);

    // Write and start while busy are ignored.
    write_word(0, 32'h11223344);
    obs.delete(); e0 = n_err;
    start_frame(1);
    write_word(0, 32'hDEADBEEF);
    #4 check("t4_wr_ready_busy", wr_ready, 0);
    start_frame(1);
    wait_idle(200);
    e = '{9'h15C, 9'h044, 9'h033, 9'h022, 9'h011, 9'h13C, 9'h0FF, 9'h055};
`ifndef DBUF_TX_SEGMENT_EN
    check_obs("t4_frame", e);
`endif
    obs.delete();
    start_frame(1); wait_idle(200);
`ifndef DBUF_TX_SEGMENT_EN
    check_obs("t4_readback", e);
`endif
    check("t4_no_err", n_err - e0, 0);

    // Reset in the middle of the payload.
    for (int i = 0; i < 4; i++) write_word(i, $urandom);
    start_frame(4);
    repeat (5) @(negedge tx_clk);
    #1 aresetn = 1'b0;
    #1 check("t5_txdata_rst", tx_data, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_charisk_rst", tx_charisk, 0);
    repeat (2) @(negedge tx_clk);
    aresetn = 1'b1;
    write_word(0, 32'h04030201);
    obs.delete(); d0 = n_done;
    start_frame(1); wait_idle(200);
    e = '{9'h15C, 9'h001, 9'h002, 9'h003, 9'h004, 9'h13C, 9'h0FF, 9'h0F5};
`ifndef DBUF_TX_SEGMENT_EN
    check_obs("t5_frame", e);
`endif
    check("t5_done_count", n_done - d0, 1);

`ifdef DBUF_TX_SEGMENT_EN
    seg_id = 8'h07;
    obs.delete();
    start_frame(1); wait_idle(200);
    e = '{9'h15C, 9'h007, 9'h001, 9'h002, 9'h003, 9'h004, 9'h13C, 9'h0FF, 9'h0EE};
    check_obs("t6_seg_frame", e);
`endif

    // Randomised frames against the model.
    for (int it = 0; it < 40; it++) begin
      slot_mode = $urandom_range(0, 2);
      n = $urandom_range(1, 8);
`ifdef DBUF_TX_SEGMENT_EN
      seg_id = 8'($urandom);
`endif
      for (int i = 1; i < n; i++) write_word(i, $urandom);
      if ($urandom_range(0, 1) == 1) write_and_start(0, $urandom, n);
      else begin write_word(0, $urandom); start_frame(n); end
      if ($urandom_range(0, 1) == 1) write_and_start($urandom_range(0, 7), $urandom, $urandom_range(0, 600));
      wait_idle(800);
      if ($urandom_range(0, 3) == 0) start_frame($urandom_range(0, 1) == 1 ? 0 : DEPTH + 1 + $urandom_range(0, 100));
    end
    repeat (3) @(negedge tx_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbuf_tx_framer.md
Name: dbuf_tx_framer

Overview:
- Parametrised single-clock data-buffer transmitter for the EVR/EVG 8b/10b link. Successor to the fixed FIFO-based buffer sender.
- Software fills an addressed word RAM of DEPTH words, then issues a start with a word count.
- The block emits a framed segment on the buffer byte slot: K28.2, payload, K28.1, then a 16-bit checksum.
- It sits between the MMR front-end and the transceiver byte mux, all in the tx_clk domain.

Parameters:
DEPTH, 512, buffer size in 32-bit words (power of two, 4..2048)
ADDR_W, $clog2(DEPTH), word address width (derived, not overridden)
LEN_W, $clog2(DEPTH)+1, word-count width
K_START, 8'h5C, start control character (K28.2)
K_STOP, 8'h3C, stop control character (K28.1)

Ports:
tx_clk  in  1  single clock for all logic
aresetn  in  1  asynchronous active-low reset; deassertion synchronised externally to tx_clk
wr_valid  in  1  buffer write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  word address
wr_data  in  32  word data
start  in  1  single-cycle transmit request
len  in  LEN_W  words to send, sampled with start
tx_slot  in  1  high in cycles whose byte belongs to the data buffer
tx_data  out  8  byte to transceiver
tx_charisk  out  1  tx_data is a K character
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last checksum byte
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset: all outputs 0, wr_ready=1, FSM in IDLE. RAM contents are not reset.
- Reset mid-frame: outputs go to 0 immediately (async), FSM returns to IDLE, and no done pulse is produced.
- Buffer RAM is synchronous with 1-cycle read latency.
- Writes are accepted only in IDLE (wr_ready = !busy). In other states writes are ignored and RAM is unchanged.
- Start handling in IDLE:
  - len==0 or len>DEPTH: start rejected, err=1 next cycle, state unchanged.
  - Otherwise: len latched, word 0 read is issued, busy=1 next cycle, state -> PRE.
- Start while busy is ignored, with no err.
- start coincident with an accepted write in IDLE: write completes; frame reads the new data.
- FSM states: IDLE, PRE, SOF, DATA, EOF, CSH, CSL.
  - PRE: waits one cycle for RAM data -> SOF.
  - SOF, DATA, EOF, CSH, CSL advance only on tx_slot cycles. Non-slot cycles hold state.
- Output per slot:
  - SOF: K_START, charisk=1.
  - DATA: bytes of each word LSB first (byte0..byte3), charisk=0. Next word is prefetched during byte3, so there are no gaps. After byte3 of word len-1 -> EOF.
  - EOF: K_STOP, charisk=1.
  - CSH: checksum[15:8].
  - CSL: checksum[7:0]; then IDLE, done=1 for one cycle, busy=0.
- tx_data/tx_charisk are 0 when tx_slot=0 or state is IDLE/PRE. Outputs are combinational from registered state and tx_slot.
- Checksum: 16-bit register, loaded with 16'hFFFF on start acceptance, minus each payload byte (zero-extended), modulo 2^16. Control characters are excluded.
- Byte index is 2 bits and wraps; word index is LEN_W bits.
- Frame length in slots = 4*len + 4.

Optional Feature:
- Macro: DBUF_TX_SEGMENT_EN.
- Defined:
  - Adds input seg_id[7:0], latched with start.
  - seg_id is emitted as a data byte in the slot immediately after K_START (new state SEG between SOF and DATA) and is included in the checksum.
  - Frame length becomes 4*len + 5.
- Undefined: seg_id port and SEG state are absent; frame as above.

Test Plan:
- Write word 0 = 32'h04030201, start len=1, tx_slot toggling every cycle -> slot bytes 5C(k), 01, 02, 03, 04, 3C(k), FF, F5; done pulses once; busy low afterwards.
- Words 0..1 = 32'h00000000, 32'hFFFFFFFF, len=2, tx_slot constant 1 -> 12 bytes, checksum FC03, no idle gaps between words.
- DEPTH=512, all words 32'hFFFFFFFF, len=512 -> checksum wraps to 07FF; len=513 -> err pulse, busy stays 0.
- Write and start while busy -> wr_ready=0, RAM unchanged (readback via a second frame), no err, current frame unaffected.
- Assert aresetn low in the middle of DATA -> tx_data=0, busy=0 immediately; after release a new len=1 frame is correct.
- With DBUF_TX_SEGMENT_EN, seg_id=8'h07, word 32'h04030201 -> 5C(k), 07, 01, 02, 03, 04, 3C(k), FF, EE.
